pwm_multi: RTL
==============

Name: pwm_multi

Overview:
- N-channel PWM generator sharing one period counter; parametrised successor of the single-channel 1 kHz PWM.
- Adds a runtime-programmable period, per-channel duty and edge- or center-aligned mode.
- Period, duty and mode are double-buffered: a load takes effect only at a period boundary, so motor outputs never glitch.
- Sits between the motor-control logic and the motor driver pins; a period-start strobe is provided for synchronous sampling.

Parameters:
- CHANNELS, 2, number of PWM outputs.
- CW, 16, counter, period and duty width in bits.
- PERIOD_RST, 16000, active period after reset (1 kHz at 16 MHz clk).

Ports:
- clk  in  1  system clock (16 MHz WF_CLK).
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures period_in, duty_in and mode_in.
- period_in  in  CW  requested period, in clk cycles (edge mode) or half-cycles count (center mode).
- duty_in  in  CHANNELS*CW  packed duties; channel i occupies bits [i*CW +: CW].
- mode_in  in  1  0 = edge-aligned, 1 = center-aligned.
- ch_en  in  CHANNELS  per-channel output enable; not buffered.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_tick  out  1  one-cycle pulse in each cycle where cnt == 0.
- load_pending  out  1  a captured load is waiting for the next boundary.

Behaviour:
- Reset (rst high at a clk edge):
  - cnt = 0, direction = up.
  - Active period = PERIOD_RST, active duties = 0, active mode = 0.
  - Pending registers = 0, load_pending = 0, pwm_out = 0, period_tick = 0.
  - Reset overrides load and cancels any pending load mid-period.
- Edge mode, active period P >= 1: cnt runs 0,1,..,P-1 and wraps to 0.
- Center mode, P >= 1:
  - cnt runs up 0..P, then down P-1..1, then to 0; one period = 2P cycles.
  - P = 1 gives the sequence 0,1,0,1,...
- P = 0 (either mode): cnt holds 0, pwm_out forced 0, and every cycle is a boundary.
- Boundary: the clk edge at which cnt takes the value 0 after counting (wrap, or bottom of the down-count).
- Shadow transfer at a boundary edge:
  - If load is high that cycle, the load_* values go directly to active; load_pending stays 0.
  - Else, if load_pending = 1, pending goes to active and load_pending clears.
  - A mode change restarts the counter at 0 counting up.
- load outside a boundary cycle: values are captured into pending and load_pending = 1 on the next cycle. A later load before the boundary overwrites pending (last write wins).
- Compare: pwm_out[i](t+1) = ch_en[i](t) & (cnt(t) < duty_act[i](t)), i.e. one-cycle registered latency.
  - Duty 0 gives a constant low output.
  - Edge mode, duty >= P: constant high. High time = duty cycles per P.
  - Center mode: high time = 2*duty-1 cycles per 2P for 1 <= duty <= P; duty > P gives constant high. The pulse is symmetric about cnt = 0.
- ch_en deassert: pwm_out[i] goes low on the next edge, regardless of counter position. Reassert resumes the compare with no re-sync.
- period_tick(t+1) = (cnt(t) == 0); registered, aligned with pwm_out.
- Arithmetic is unsigned, CW bits. The counter never exceeds P, so there is no overflow.

Test Plan:
- Reset, then idle 20000 cycles -> period_tick every 16000 cycles; pwm_out = 0 throughout.
- load with P=10, duty ch0=3, ch1=10, edge mode, ch_en=11 at a boundary -> ch0 high 3 of every 10 cycles; ch1 constant high; tick period 10.
- Mid-period load of duty ch0=7 at cnt=4 -> load_pending=1 until the wrap; current period keeps duty 3; next period high 7 cycles; load_pending returns to 0 at cnt=0.
- Center mode P=8, duty ch0=3 -> ch0 high 5 of every 16 cycles, centred on cnt=0; duty 9 -> constant high; duty 0 -> constant low.
- ch_en[0] dropped at cnt=1 with duty 5 -> pwm_out[0] low the next cycle; ch1 unaffected. Then rst asserted mid-period with load_pending=1 -> all outputs 0; period reverts to 16000; pending load discarded.
- load P=0 -> pwm_out held 0, period_tick high every cycle; subsequent load P=4 takes effect on the very next cycle.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM sharing one edge/center-aligned counter, with period/duty/mode
// double-buffered so that new settings only take effect at a period boundary.
module pwm_multi #(
    parameter int          CHANNELS   = 2,
    parameter int          CW         = 16,
    parameter int unsigned PERIOD_RST = 16000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [CW-1:0]          period_in,
    input  logic [CHANNELS*CW-1:0] duty_in,
    input  logic                   mode_in,
    input  logic [CHANNELS-1:0]    ch_en,
    output logic [CHANNELS-1:0]    pwm_out,
    output logic                   period_tick,
    output logic                   load_pending
);
    logic [CW-1:0]          cnt_q, cnt_d, per_q, per_d, pper_q, pper_d;
    logic [CHANNELS*CW-1:0] duty_q, duty_d, pduty_q, pduty_d;
    logic                   up_q, up_d, mode_q, mode_d, pmode_q, pmode_d, pend_q, pend_d;
    logic [CHANNELS-1:0]    pwm_q, pwm_d;
    logic                   tick_q, tick_d, bnd, down;

    always_comb begin
        // down: center mode counting down, either already descending or sitting at the top
        down    = mode_q && (!up_q || cnt_q >= per_q);
        bnd     = (per_q == '0) || (mode_q ? (down && cnt_q <= CW'(1)) : (cnt_q >= per_q - CW'(1)));
        cnt_d   = bnd ? '0 : down ? cnt_q - CW'(1) : cnt_q + CW'(1);
        up_d    = bnd || !down;
        per_d   = (bnd && load) ? period_in : (bnd && pend_q) ? pper_q  : per_q;
        duty_d  = (bnd && load) ? duty_in   : (bnd && pend_q) ? pduty_q : duty_q;
        mode_d  = (bnd && load) ? mode_in   : (bnd && pend_q) ? pmode_q : mode_q;
        pend_d  = !bnd && (load || pend_q);
        pper_d  = (!bnd && load) ? period_in : pper_q;
        pduty_d = (!bnd && load) ? duty_in   : pduty_q;
        pmode_d = (!bnd && load) ? mode_in   : pmode_q;
        tick_d  = cnt_q == '0;
        pwm_d   = '0;
        for (int i = 0; i < CHANNELS; i++)
            pwm_d[i] = ch_en[i] && per_q != '0 && cnt_q < duty_q[i*CW +: CW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            up_q    <= 1'b1;
            per_q   <= CW'(PERIOD_RST);
            duty_q  <= '0;
            mode_q  <= 1'b0;
            pper_q  <= '0;
            pduty_q <= '0;
            pmode_q <= 1'b0;
            pend_q  <= 1'b0;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            per_q   <= per_d;
            duty_q  <= duty_d;
            mode_q  <= mode_d;
            pper_q  <= pper_d;
            pduty_q <= pduty_d;
            pmode_q <= pmode_d;
            pend_q  <= pend_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_tick  = tick_q;
    assign load_pending = pend_q;
endmodule
